mem_arbiter: RTL and testbench

- Shares the single physical-memory line port between the instruction cache (read-only) and the data cache (read/write) in the pipelined LC-3b core.
- Sits between both L1 caches and the pmem/L2 interface.
- Uses a registered grant state machine and latches each request, so pmem sees stable signals for the whole transaction.
- Default priority is D-cache, because a data miss belongs to the older instruction; a streak counter prevents I-cache starvation.

---
 rtl/mem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single pmem/L2 line port between the instruction cache (read-only)
//   and the data cache (read/write). A registered grant FSM latches each request
//   so pmem sees stable signals for the whole transaction. D-cache has default
//   priority; a streak counter bounds consecutive D grants while an I request
//   waits, so the I-cache cannot starve.
//
//   Optional feature: define MEM_ARB_PERF_CNT_EN to add three 16-bit wrapping
//   performance counters (perf_i_grants, perf_d_grants, perf_conflicts).
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   icache_pmem_*           I-cache side: read level + address in, resp/rdata out
//   dcache_pmem_*           D-cache side: read/write levels, address, wdata in,
//                           resp/rdata out
//   pmem_*                  memory side: read/write strobes, address, wdata out,
//                           resp/rdata in
//   perf_*                  (MEM_ARB_PERF_CNT_EN only) grant and conflict counters
module mem_arbiter #(
   parameter int unsigned ADDR_WIDTH   = 16,
   parameter int unsigned LINE_WIDTH   = 128,
   parameter int unsigned MAX_D_STREAK = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  icache_pmem_read,
   input  logic [ADDR_WIDTH-1:0] icache_pmem_address,
   output logic                  icache_pmem_resp,
   output logic [LINE_WIDTH-1:0] icache_pmem_rdata,
   input  logic                  dcache_pmem_read,
   input  logic                  dcache_pmem_write,
   input  logic [ADDR_WIDTH-1:0] dcache_pmem_address,
   input  logic [LINE_WIDTH-1:0] dcache_pmem_wdata,
   output logic                  dcache_pmem_resp,
   output logic [LINE_WIDTH-1:0] dcache_pmem_rdata,
   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [ADDR_WIDTH-1:0] pmem_address,
   output logic [LINE_WIDTH-1:0] pmem_wdata,
   input  logic                  pmem_resp,
   input  logic [LINE_WIDTH-1:0] pmem_rdata
`ifdef MEM_ARB_PERF_CNT_EN
   ,
   output logic [15:0]           perf_i_grants,
   output logic [15:0]           perf_d_grants,
   output logic [15:0]           perf_conflicts
`endif
);

   localparam logic [1:0] s_idle    = 2'd0;
   localparam logic [1:0] s_serve_i = 2'd1;
   localparam logic [1:0] s_serve_d = 2'd2;
   localparam logic [1:0] s_release = 2'd3;

   localparam logic [3:0] MaxStreak = 4'(MAX_D_STREAK);

   logic [1:0]            state_q, state_d;
   logic [3:0]            streak_q, streak_d;
   logic                  lat_write_q;
   logic [ADDR_WIDTH-1:0] lat_addr_q;
   logic [LINE_WIDTH-1:0] lat_wdata_q;

   logic d_req;
   logic grant_d;
   logic grant_i;
   logic serve_i;
   logic serve_d;

   // Arbitration is only evaluated in s_idle; D wins unless the I-cache has
   // already waited through MAX_D_STREAK consecutive D grants.
   always_comb begin
      d_req   = dcache_pmem_read | dcache_pmem_write;
      grant_d = 1'b0;
      grant_i = 1'b0;
      if (state_q == s_idle) begin
         if (d_req && (!icache_pmem_read || (streak_q < MaxStreak))) begin
            grant_d = 1'b1;
         end else if (icache_pmem_read) begin
            grant_i = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         s_idle: begin
            if (grant_d) begin
               state_d = s_serve_d;
            end else if (grant_i) begin
               state_d = s_serve_i;
            end
         end
         s_serve_i, s_serve_d: begin
            if (pmem_resp) begin
               state_d = s_release;
            end
         end
         s_release: state_d = s_idle;
         default:   state_d = s_idle;
      endcase
   end

   always_comb begin
      streak_d = streak_q;
      if (grant_i) begin
         streak_d = 4'd0;
      end else if (grant_d) begin
         if (icache_pmem_read) begin
            streak_d = (streak_q == MaxStreak) ? streak_q : streak_q + 4'd1;
         end else begin
            streak_d = 4'd0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= s_idle;
         streak_q    <= 4'd0;
         lat_write_q <= 1'b0;
         lat_addr_q  <= '0;
         lat_wdata_q <= '0;
      end else begin
         state_q  <= state_d;
         streak_q <= streak_d;
         if (grant_d) begin
            // A simultaneous read+write from the D-cache is treated as a write.
            lat_write_q <= dcache_pmem_write;
            lat_addr_q  <= dcache_pmem_address;
            lat_wdata_q <= dcache_pmem_wdata;
         end else if (grant_i) begin
            lat_write_q <= 1'b0;
            lat_addr_q  <= icache_pmem_address;
            lat_wdata_q <= '0;
         end
      end
   end

   // pmem sees only the latched copy, so requesters may change or drop their
   // lines mid-transaction without disturbing memory.
   always_comb begin
      serve_i           = (state_q == s_serve_i);
      serve_d           = (state_q == s_serve_d);
      pmem_read         = serve_i | (serve_d & ~lat_write_q);
      pmem_write        = serve_d & lat_write_q;
      pmem_address      = lat_addr_q;
      pmem_wdata        = lat_wdata_q;
      icache_pmem_resp  = serve_i & pmem_resp;
      dcache_pmem_resp  = serve_d & pmem_resp;
      icache_pmem_rdata = pmem_rdata;
      dcache_pmem_rdata = pmem_rdata;
   end

`ifdef MEM_ARB_PERF_CNT_EN
   logic [15:0] perf_i_q;
   logic [15:0] perf_d_q;
   logic [15:0] perf_conf_q;
   logic        conflict;

   assign conflict = (state_q == s_idle) & icache_pmem_read & d_req;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_i_q    <= 16'd0;
         perf_d_q    <= 16'd0;
         perf_conf_q <= 16'd0;
      end else begin
         if (grant_i) begin
            perf_i_q <= perf_i_q + 16'd1;
         end
         if (grant_d) begin
            perf_d_q <= perf_d_q + 16'd1;
         end
         if (conflict) begin
            perf_conf_q <= perf_conf_q + 16'd1;
         end
      end
   end

   assign perf_i_grants  = perf_i_q;
   assign perf_d_grants  = perf_d_q;
   assign perf_conflicts = perf_conf_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter. Cache agents serve request queues, a
//   memory agent answers strobes after a random delay, a transaction-level model
//   predicts each grant, and a monitor compares what pmem actually sees.
module tb_mem_arbiter;

   localparam int unsigned AW   = 16;
   localparam int unsigned LW   = 128;
   localparam int unsigned MAXS = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          icache_pmem_read = 1'b0;
   logic [AW-1:0] icache_pmem_address = '0;
   logic          icache_pmem_resp;
   logic [LW-1:0] icache_pmem_rdata;
   logic          dcache_pmem_read = 1'b0;
   logic          dcache_pmem_write = 1'b0;
   logic [AW-1:0] dcache_pmem_address = '0;
   logic [LW-1:0] dcache_pmem_wdata = '0;
   logic          dcache_pmem_resp;
   logic [LW-1:0] dcache_pmem_rdata;
   logic          pmem_read;
   logic          pmem_write;
   logic [AW-1:0] pmem_address;
   logic [LW-1:0] pmem_wdata;
   logic          pmem_resp = 1'b0;
   logic [LW-1:0] pmem_rdata = '0;
`ifdef MEM_ARB_PERF_CNT_EN
   logic [15:0]   perf_i_grants;
   logic [15:0]   perf_d_grants;
   logic [15:0]   perf_conflicts;
`endif

   mem_arbiter #(
      .ADDR_WIDTH  (AW),
      .LINE_WIDTH  (LW),
      .MAX_D_STREAK(MAXS)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .icache_pmem_read   (icache_pmem_read),
      .icache_pmem_address(icache_pmem_address),
      .icache_pmem_resp   (icache_pmem_resp),
      .icache_pmem_rdata  (icache_pmem_rdata),
      .dcache_pmem_read   (dcache_pmem_read),
      .dcache_pmem_write  (dcache_pmem_write),
      .dcache_pmem_address(dcache_pmem_address),
      .dcache_pmem_wdata  (dcache_pmem_wdata),
      .dcache_pmem_resp   (dcache_pmem_resp),
      .dcache_pmem_rdata  (dcache_pmem_rdata),
      .pmem_read          (pmem_read),
      .pmem_write         (pmem_write),
      .pmem_address       (pmem_address),
      .pmem_wdata         (pmem_wdata),
      .pmem_resp          (pmem_resp),
      .pmem_rdata         (pmem_rdata)
`ifdef MEM_ARB_PERF_CNT_EN
      ,
      .perf_i_grants      (perf_i_grants),
      .perf_d_grants      (perf_d_grants),
      .perf_conflicts     (perf_conflicts)
`endif
   );

   typedef struct {
      logic          rd;
      logic          wr;
      logic [AW-1:0] addr;
      logic [LW-1:0] wdata;
   } req_t;

   typedef struct {
      logic          is_d;
      logic          wr;
      logic [AW-1:0] addr;
      logic [LW-1:0] wdata;
      int unsigned   gcyc;
   } txn_t;

   req_t iq[$], dq[$], iq_new[$], dq_new[$];
   txn_t expq[$];
   int   grant_log[$];

   int checks = 0;
   int errors = 0;

   int unsigned cyc = 0;
   logic auto_en = 1'b0;
   logic gen_en  = 1'b0;

   // model state
   int   mphase = 0;  // 0 arbiter free, 1 transaction open, 2 release cycle
   int   streak = 0;
   logic cur_is_d = 1'b0;
   logic i_granted = 1'b0, d_granted = 1'b0;
   logic i_done = 1'b0, d_done = 1'b0;
   int   model_ig = 0, model_dg = 0, model_conf = 0;

   // monitor state
   logic active = 1'b0;
   logic strobe_prev = 1'b0;
   txn_t cur;

   task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic stage_i(input logic [AW-1:0] a);
      req_t r;
      r.rd = 1'b1; r.wr = 1'b0; r.addr = a; r.wdata = '0;
      iq_new.push_back(r);
   endtask

   task automatic stage_d(input logic rd, input logic wr, input logic [AW-1:0] a,
                          input logic [LW-1:0] wd);
      req_t r;
      r.rd = rd; r.wr = wr; r.addr = a; r.wdata = wd;
      dq_new.push_back(r);
   endtask

   function automatic logic [LW-1:0] rand_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial forever #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Cache agents and memory agent: everything driven #1 after the rising edge.
   initial begin
      int   mcnt;
      logic mbusy;
      mcnt  = 0;
      mbusy = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (auto_en) begin
            if (i_done) begin
               void'(iq.pop_front());
               i_done = 1'b0;
               i_granted = 1'b0;
            end
            if (d_done) begin
               void'(dq.pop_front());
               d_done = 1'b0;
               d_granted = 1'b0;
            end
            while (iq_new.size() > 0) iq.push_back(iq_new.pop_front());
            while (dq_new.size() > 0) dq.push_back(dq_new.pop_front());
            if (gen_en) begin
               if (iq.size() < 3 && $urandom_range(0, 99) < 30) begin
                  req_t r;
                  r.rd = 1'b1; r.wr = 1'b0; r.addr = AW'($urandom); r.wdata = '0;
                  iq.push_back(r);
               end
               if (dq.size() < 3 && $urandom_range(0, 99) < 40) begin
                  req_t r;
                  int op;
                  op = $urandom_range(0, 2);
                  r.rd = (op != 1); r.wr = (op != 0);
                  r.addr = AW'($urandom); r.wdata = rand_line();
                  dq.push_back(r);
               end
            end
            // A granted requester scribbles on its lines; the arbiter must ignore it.
            if (i_granted) begin
               icache_pmem_read    = 1'($urandom_range(0, 1));
               icache_pmem_address = AW'($urandom);
            end else if (iq.size() > 0) begin
               icache_pmem_read    = 1'b1;
               icache_pmem_address = iq[0].addr;
            end else begin
               icache_pmem_read    = 1'b0;
               icache_pmem_address = AW'($urandom);
            end
            if (d_granted) begin
               dcache_pmem_read    = 1'($urandom_range(0, 1));
               dcache_pmem_write   = 1'($urandom_range(0, 1));
               dcache_pmem_address = AW'($urandom);
               dcache_pmem_wdata   = rand_line();
            end else if (dq.size() > 0) begin
               dcache_pmem_read    = dq[0].rd;
               dcache_pmem_write   = dq[0].wr;
               dcache_pmem_address = dq[0].addr;
               dcache_pmem_wdata   = dq[0].wdata;
            end else begin
               dcache_pmem_read    = 1'b0;
               dcache_pmem_write   = 1'b0;
               dcache_pmem_address = AW'($urandom);
               dcache_pmem_wdata   = rand_line();
            end
            // memory: random 0..4 wait, plus occasional stale resp while idle
            pmem_rdata = rand_line();
            if (pmem_resp) begin
               pmem_resp = 1'b0;
               mbusy = 1'b0;
            end else if (pmem_read || pmem_write) begin
               if (!mbusy) begin
                  mbusy = 1'b1;
                  mcnt  = $urandom_range(0, 4);
               end
               if (mcnt == 0) pmem_resp = 1'b1;
               else mcnt--;
            end else if ($urandom_range(0, 15) == 0) begin
               pmem_resp = 1'b1;
            end
         end
      end
   end

   // Reference model: one transaction at a time, D preferred unless the I side
   // has watched MAXS D grants in a row; one dead cycle after each completion.
   always @(negedge clk) begin
      if (auto_en) begin
         case (mphase)
            0: begin
               txn_t t;
               logic ip, dp;
               ip = (iq.size() > 0);
               dp = (dq.size() > 0);
               if (ip && dp) model_conf++;
               if (dp && (!ip || streak < MAXS)) begin
                  t.is_d = 1'b1; t.wr = dq[0].wr; t.addr = dq[0].addr;
                  t.wdata = dq[0].wdata; t.gcyc = cyc;
                  streak = ip ? streak + 1 : 0;
                  d_granted = 1'b1; cur_is_d = 1'b1; model_dg++;
                  expq.push_back(t);
                  mphase = 1;
               end else if (ip) begin
                  t.is_d = 1'b0; t.wr = 1'b0; t.addr = iq[0].addr;
                  t.wdata = '0; t.gcyc = cyc;
                  streak = 0;
                  i_granted = 1'b1; cur_is_d = 1'b0; model_ig++;
                  expq.push_back(t);
                  mphase = 1;
               end
            end
            1: begin
               if (pmem_resp) begin
                  if (cur_is_d) d_done = 1'b1;
                  else i_done = 1'b1;
                  mphase = 2;
               end
            end
            default: mphase = 0;
         endcase
      end
   end

   // Monitor: compares what the DUT presents against the queued expectations.
   always @(negedge clk) begin
      if (auto_en) begin
         logic strobe;
         strobe = pmem_read | pmem_write;
         chk("rw_exclusive", LW'(pmem_read & pmem_write), '0);
         if (strobe && !strobe_prev) begin
            checks++;
            if (expq.size() == 0) begin
               errors++;
               $display("FAIL grant_unexpected: got strobe addr %0h expected none", pmem_address);
            end else begin
               cur = expq.pop_front();
               active = 1'b1;
               chk("grant_latency", LW'(cyc), LW'(cur.gcyc + 1));
               chk("grant_write", LW'(pmem_write), LW'(cur.wr));
               chk("grant_read", LW'(pmem_read), LW'(!cur.wr));
            end
         end
         if (strobe && !active) begin
            checks++;
            errors++;
            $display("FAIL strobe_outside_txn: got rd=%0b wr=%0b expected 0", pmem_read,
                     pmem_write);
         end
         if (active) begin
            chk("pmem_address", LW'(pmem_address), LW'(cur.addr));
            if (cur.wr) chk("pmem_wdata", pmem_wdata, cur.wdata);
         end
         if (dcache_pmem_resp) grant_log.push_back(1);
         else if (icache_pmem_resp) grant_log.push_back(0);
         if (active && pmem_resp) begin
            chk("icache_resp", LW'(icache_pmem_resp), LW'(!cur.is_d));
            chk("dcache_resp", LW'(dcache_pmem_resp), LW'(cur.is_d));
            chk("icache_rdata", icache_pmem_rdata, pmem_rdata);
            chk("dcache_rdata", dcache_pmem_rdata, pmem_rdata);
            active = 1'b0;
         end else begin
            chk("no_icache_resp", LW'(icache_pmem_resp), '0);
            chk("no_dcache_resp", LW'(dcache_pmem_resp), '0);
         end
         strobe_prev = strobe;
      end
   end

   task automatic drain(input string name);
      int g;
      g = 0;
      while ((iq_new.size() > 0 || dq_new.size() > 0 || iq.size() > 0 || dq.size() > 0 ||
              mphase != 0 || active) && g < 3000) begin
         @(posedge clk);
         g++;
      end
      chk({"drain_", name}, LW'(g < 3000), LW'(1));
      repeat (2) @(posedge clk);
   endtask

   task automatic check_log(input string name, input int exp_seq[$]);
      chk({name, "_count"}, LW'(grant_log.size()), LW'(exp_seq.size()));
      for (int k = 0; k < exp_seq.size() && k < grant_log.size(); k++) begin
         chk($sformatf("%s_%0d", name, k), LW'(grant_log[k]), LW'(exp_seq[k]));
      end
   endtask

   initial begin
      int exp_seq[$];
      #1;
      chk("rst_pmem_read", LW'(pmem_read), '0);
      chk("rst_pmem_write", LW'(pmem_write), '0);
      chk("rst_pmem_address", LW'(pmem_address), '0);
      chk("rst_pmem_wdata", pmem_wdata, '0);
      chk("rst_icache_resp", LW'(icache_pmem_resp), '0);
      chk("rst_dcache_resp", LW'(dcache_pmem_resp), '0);
      repeat (3) @(posedge clk);
      #1;
      reset   = 1'b0;
      auto_en = 1'b1;

      // single I read
      grant_log.delete();
      stage_i(16'h1230);
      drain("single_i");
      exp_seq = '{0};
      check_log("single_i", exp_seq);

      // simultaneous I read and D write: D first
      grant_log.delete();
      stage_i(16'h0040);
      stage_d(1'b0, 1'b1, 16'h8000, rand_line());
      drain("conflict");
      exp_seq = '{1, 0};
      check_log("conflict", exp_seq);

      // starvation guard: I waits through exactly MAXS D grants
      grant_log.delete();
      stage_i(16'h0100);
      for (int k = 0; k < 6; k++) stage_d(1'b1, 1'b0, AW'(16'h0200 + k * 16), rand_line());
      drain("streak");
      exp_seq = '{1, 1, 1, 1, 0, 1, 1};
      check_log("streak", exp_seq);

      // read+write together resolves to write
      grant_log.delete();
      stage_d(1'b1, 1'b1, 16'h2000, rand_line());
      drain("rw_both");
      exp_seq = '{1};
      check_log("rw_both", exp_seq);

      // randomized traffic
      gen_en = 1'b1;
      repeat (1500) @(posedge clk);
      gen_en = 1'b0;
      drain("random");
      chk("expq_empty", LW'(expq.size()), '0);

`ifdef MEM_ARB_PERF_CNT_EN
      chk("perf_i_grants", LW'(perf_i_grants), LW'(16'(model_ig)));
      chk("perf_d_grants", LW'(perf_d_grants), LW'(16'(model_dg)));
      chk("perf_conflicts", LW'(perf_conflicts), LW'(16'(model_conf)));
`endif

      // asynchronous reset in the middle of a D read
      @(negedge clk);
      auto_en = 1'b0;
      @(posedge clk);
      #2;
      pmem_resp           = 1'b0;
      icache_pmem_read    = 1'b0;
      dcache_pmem_read    = 1'b1;
      dcache_pmem_write   = 1'b0;
      dcache_pmem_address = 16'h4444;
      @(posedge clk);
      #2;
      chk("mid_rst_pre_read", LW'(pmem_read), LW'(1));
      chk("mid_rst_pre_addr", LW'(pmem_address), LW'(16'h4444));
      dcache_pmem_read = 1'b0;
      #1;
      reset = 1'b1;
      #1;
      chk("mid_rst_pmem_read", LW'(pmem_read), '0);
      chk("mid_rst_pmem_write", LW'(pmem_write), '0);
      chk("mid_rst_pmem_address", LW'(pmem_address), '0);
      chk("mid_rst_pmem_wdata", pmem_wdata, '0);
`ifdef MEM_ARB_PERF_CNT_EN
      chk("mid_rst_perf_i", LW'(perf_i_grants), '0);
      chk("mid_rst_perf_d", LW'(perf_d_grants), '0);
      chk("mid_rst_perf_conf", LW'(perf_conflicts), '0);
`endif
      @(posedge clk);
      #2;
      reset = 1'b0;
      @(posedge clk);
      #2;
      pmem_resp = 1'b1;
      #1;
      chk("stale_icache_resp", LW'(icache_pmem_resp), '0);
      chk("stale_dcache_resp", LW'(dcache_pmem_resp), '0);
      chk("stale_pmem_read", LW'(pmem_read), '0);
      @(posedge clk);
      #2;
      pmem_resp = 1'b0;
      @(posedge clk);
      #2;
      chk("post_stale_idle", LW'(pmem_read | pmem_write), '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1);
   end

endmodule
